block_mem_responder: RTL and testbench

Line-granular data-memory responder on the far side of the cache-to-memory interface. It accepts one block read or block write at a time from the cache controller, holds the request for a fixed (optionally jittered) latency, then either returns a full line with a one-cycle valid pulse or commits the line to storage. It replaces the behavioural memory behind the cache in simulation and is the synthesizable target for the lab5 memory hierarchy.

---
 rtl/block_mem_responder_pkg.sv | 21 ++
 rtl/block_mem_responder_lfsr8.sv | 33 +++
 rtl/block_mem_responder.sv | 125 ++++++++++++
 tb/tb_block_mem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_responder_pkg.sv
// Shared state encoding, default parameters, line-width macro and LFSR seed
// for block_mem_responder.
`ifndef BMR_LINE_W
`define BMR_LINE_W(bs) ((bs) * 8)
`endif

package block_mem_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE    = 2'd0,
        RSP_BUSY    = 2'd1,
        RSP_RESPOND = 2'd2
    } rsp_state_e;

    localparam int unsigned DEFAULT_BLOCK_SIZE = 16;
    localparam int unsigned DEFAULT_NUM_LINES  = 16384;
    localparam int unsigned DEFAULT_DELAY      = 50;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/block_mem_responder_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) for latency jitter; the module exists
// only when DMEM_RANDOM_LATENCY_EN is defined.
`ifdef DMEM_RANDOM_LATENCY_EN
module lfsr8
    import block_mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = {value_q[6:0], value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule
`endif

// File: rtl/block_mem_responder.sv
// Line-granular memory responder: one block read/write at a time, fixed busy
// latency (extra 0-7 cycles of jitter when DMEM_RANDOM_LATENCY_EN is defined).
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int unsigned NUM_LINES  = DEFAULT_NUM_LINES,
    parameter int unsigned DELAY      = DEFAULT_DELAY
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                is_input_valid,
    input  logic [31:0]                         addr,
    input  logic                                mem_read,
    input  logic                                mem_write,
    input  logic [`BMR_LINE_W(BLOCK_SIZE)-1:0]  din,
    output logic                                is_output_valid,
    output logic [`BMR_LINE_W(BLOCK_SIZE)-1:0]  dout,
    output logic                                mem_ready
);

    localparam int unsigned DW = `BMR_LINE_W(BLOCK_SIZE);
    localparam int unsigned LW = $clog2(NUM_LINES);
    localparam int unsigned CW = $clog2(DELAY + 8);
    localparam logic [CW-1:0] BASE_LOAD = CW'(DELAY - 1);

    rsp_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, load_val;
    logic [LW-1:0] line_q, line_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] dout_q;
    logic          rd_q, rd_d;
    logic          valid_q;
    logic          accept, fetch, commit;
    logic          unused_addr;

    logic [DW-1:0] mem_q [NUM_LINES] = '{default: '0};

    assign unused_addr = ^addr[31:LW];

`ifdef DMEM_RANDOM_LATENCY_EN
    logic [7:0] lfsr_val;
    logic       unused_lfsr;

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr_val)
    );

    assign load_val    = BASE_LOAD + CW'(lfsr_val[2:0]);
    assign unused_lfsr = ^lfsr_val[7:3];
`else
    assign load_val = BASE_LOAD;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        din_d   = din_q;
        rd_d    = rd_q;
        accept  = 1'b0;
        unique case (state_q)
            RSP_IDLE: begin
                if (is_input_valid && (mem_read ^ mem_write)) begin
                    accept  = 1'b1;
                    state_d = RSP_BUSY;
                    cnt_d   = load_val;
                    line_d  = addr[LW-1:0];
                    din_d   = din;
                    rd_d    = mem_read;
                end
            end
            RSP_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RSP_RESPOND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RSP_RESPOND: state_d = RSP_IDLE;
            default:     state_d = RSP_IDLE;
        endcase
    end

    // Read data is fetched on the last BUSY edge so it is already registered
    // during RESPOND; the write port is used only in RESPOND.
    assign fetch  = (state_q == RSP_BUSY) && (cnt_q == '0) && rd_q;
    assign commit = (state_q == RSP_RESPOND) && !rd_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= fetch;
            if (fetch) begin
                dout_q <= mem_q[line_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
        din_q  <= din_d;
        rd_q   <= rd_d;
    end

    always_ff @(posedge clk) begin
        if (reset && commit) begin
            mem_q[line_q] <= din_q;
        end
    end

    assign mem_ready       = (state_q == RSP_IDLE);
    assign is_output_valid = valid_q;
    assign dout            = dout_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: directed cases plus random
// traffic against a timeline-based reference model.
module tb_block_mem_responder;

    localparam int BS  = 16;
    localparam int NL  = 16;
    localparam int DLY = 4;
    localparam int DW  = BS * 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          is_input_valid = 1'b0;
    logic [31:0]   addr = '0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [DW-1:0] din = '0;
    logic          is_output_valid;
    logic [DW-1:0] dout;
    logic          mem_ready;

    int errors = 0;
    int checks = 0;

    block_mem_responder #(
        .BLOCK_SIZE (BS),
        .NUM_LINES  (NL),
        .DELAY      (DLY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .mem_ready       (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted request owns a window of edges; the
    // response edge is accept edge + DELAY (+ jitter), the line frees one edge later.
    logic [DW-1:0] m_mem [NL];
    bit            m_live = 1'b0;
    bit            m_pend = 1'b0;
    bit            m_idle_before;
    bit            m_rd = 1'b0;
    int            m_line = 0;
    int            m_jit = 0;
    longint        m_edge = 0;
    longint        m_resp = 0;
    logic [DW-1:0] m_din = '0;
    logic [7:0]    m_lfsr = 8'hA5;
    bit            e_ready = 1'b1;
    bit            e_valid = 1'b0;
    logic [DW-1:0] e_dout = '0;

    initial foreach (m_mem[i]) m_mem[i] = '0;

    always @(posedge clk) begin
        m_edge++;
        if (!reset) begin
            m_live  = 1'b1;
            m_pend  = 1'b0;
            e_valid = 1'b0;
            e_dout  = '0;
            m_lfsr  = 8'hA5;
        end else begin
            m_idle_before = !m_pend;
            e_valid = 1'b0;
            if (m_pend && m_edge == m_resp && m_rd) begin
                e_valid = 1'b1;
                e_dout  = m_mem[m_line];
            end
            if (m_pend && m_edge == m_resp + 1) begin
                if (!m_rd) m_mem[m_line] = m_din;
                m_pend = 1'b0;
            end
            if (m_idle_before && is_input_valid && (mem_read != mem_write)) begin
                m_jit = 0;
`ifdef DMEM_RANDOM_LATENCY_EN
                m_jit  = int'(m_lfsr % 8);
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
                m_pend = 1'b1;
                m_rd   = mem_read;
                m_line = int'(addr % NL);
                m_din  = din;
                m_resp = m_edge + DLY + m_jit;
            end
        end
        e_ready = !m_pend;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("mem_ready", DW'(mem_ready), DW'(e_ready));
            check("is_output_valid", DW'(is_output_valid), DW'(e_valid));
            check("dout", dout, e_dout);
        end
    end

    task automatic send(input bit rd, input logic [31:0] a, input logic [DW-1:0] d);
        int g;
        g = 0;
        while (!mem_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("send_ready", DW'(mem_ready), DW'(1));
        is_input_valid = 1'b1;
        mem_read  = rd;
        mem_write = !rd;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        is_input_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic finish_req(output int lat, output int busy, output int pulses);
        lat = -1;
        busy = 0;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (is_output_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (mem_ready) break;
            busy++;
        end
        check("req_done", DW'(mem_ready), DW'(1));
    endtask

    task automatic do_req(input bit rd, input logic [31:0] a, input logic [DW-1:0] d,
                          output int lat, output int busy);
        int p;
        send(rd, a, d);
        finish_req(lat, busy, p);
    endtask

    localparam logic [DW-1:0] PAT = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [DW-1:0] PAT2 = 128'h0BADCAFE_00000000_11112222_33334444;

    initial begin
        int lat, busy, pulses, lats[8];
        bit stayed;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", DW'(mem_ready), DW'(1));
        check("rst_valid", DW'(is_output_valid), DW'(0));
        check("rst_dout", dout, '0);

        do_req(1'b0, 32'h10, PAT, lat, busy);
`ifndef DMEM_RANDOM_LATENCY_EN
        check("write_busy_cycles", DW'(busy), DW'(5));
`endif
        do_req(1'b1, 32'h10, '0, lat, busy);
`ifndef DMEM_RANDOM_LATENCY_EN
        check("read_latency", DW'(lat), DW'(5));
        check("read_busy_cycles", DW'(busy), DW'(5));
`endif
        check("read_data", dout, PAT);

        // read presented while busy must be dropped
        send(1'b0, 32'h20, PAT2);
        @(negedge clk);
        is_input_valid = 1'b1;
        mem_read = 1'b1;
        addr = 32'h20;
        @(negedge clk);
        is_input_valid = 1'b0;
        mem_read = 1'b0;
        finish_req(lat, busy, pulses);
        check("busy_drop_pulses", DW'(pulses), DW'(0));
        repeat (3) @(negedge clk);
        check("busy_drop_no_late_pulse", DW'(is_output_valid), DW'(0));
        do_req(1'b1, 32'h20, '0, lat, busy);
        check("busy_drop_write_kept", dout, PAT2);

        do_req(1'b0, 32'h13, 128'h1, lat, busy);
        do_req(1'b1, 32'h03, '0, lat, busy);
        check("wrap_read", dout, 128'h1);

        send(1'b0, 32'h7, 128'h5);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ready", DW'(mem_ready), DW'(1));
        do_req(1'b1, 32'h7, '0, lat, busy);
        check("midreset_discard", dout, '0);

        @(negedge clk);
        is_input_valid = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        addr = 32'h2;
        @(negedge clk);
        is_input_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check("illegal_ready", DW'(mem_ready), DW'(1));
        stayed = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!mem_ready) stayed = 1'b0;
            if (is_output_valid) pulses++;
        end
        check("illegal_ready_held", DW'(stayed), DW'(1));
        check("illegal_no_pulse", DW'(pulses), DW'(0));

`ifdef DMEM_RANDOM_LATENCY_EN
        for (int pass = 0; pass < 2; pass++) begin
            reset = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                do_req(1'b1, 32'(i), '0, lat, busy);
                if (pass == 0) begin
                    lats[i] = lat;
                    check("jitter_range", DW'(lat >= DLY + 1 && lat <= DLY + 8), DW'(1));
                end else begin
                    check("jitter_repeat", DW'(lat), DW'(lats[i]));
                end
            end
        end
`else
        lats[0] = 0;
`endif

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset = ($urandom_range(199) != 0);
            is_input_valid = ($urandom_range(3) != 0);
            {mem_read, mem_write} = 2'($urandom_range(3));
            addr = $urandom;
            din  = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        reset = 1'b1;
        is_input_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
